// File: rtl/frame_uart_sender.sv
// Reads framebuffer rows back and streams them as UART row packets.
// Each packet waits for a peer acknowledge and is resent on timeout.
module frame_uart_sender #(
  parameter int          Wight       = 640,
  parameter int          Height      = 480,
  parameter int          CLK_FREQ    = 100_000_000,
  parameter int          BAUD        = 115200,
  parameter int          STOP_BIT    = 2,
  parameter logic [7:0]  END_CODE    = 8'hFF,
  parameter logic [7:0]  ANSWER_CODE = 8'hAA,
  parameter int          RAM_LATENCY = 2,
  parameter int          ACK_TIMEOUT = 1_000_000,
  parameter int          MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  row_first,
  input  logic [8:0]  row_last,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [18:0] ram_addr,
  output logic        ram_rd,
  input  logic [2:0]  ram_q,
  input  logic        ack_valid,
  input  logic [7:0]  ack_byte,
  output logic        txd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int NB  = 9 + STOP_BIT;
  localparam int DW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);
  localparam int GW  = $clog2(Wight / 8 + 1);
  localparam int RW  = $clog2(MAX_RETRY + 2);
  localparam logic [18:0] WL = 19'(Wight);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, FETCH, SEND3, TRAIL, WAIT_ACK, NEXT
  } state_t;

  state_t st_q;

  logic [8:0]  row_q, last_q;
  logic [18:0] ptr_q;
  logic [GW-1:0] grp_q;
  logic [3:0]  rd_cnt_q;
  logic [2:0]  cap_cnt_q;
  logic [1:0]  byte_q;
  logic [23:0] sh_q;
  logic [RAM_LATENCY-1:0] pipe_q;
  logic [TW-1:0] tmo_q;
  logic [RW-1:0] retry_q;

  logic          tx_busy_q;
  logic [DW-1:0] tx_div_q;
  logic [3:0]    tx_bits_q;
  logic [NB-1:0] tx_sh_q;
  logic          tx_rdy;
  logic          tx_go;
  logic [7:0]    tx_byte;

  // A new byte may load on the last cycle of the final stop bit: no gap.
  assign tx_rdy = !tx_busy_q ||
                  (tx_div_q == '0 && tx_bits_q == '0);
  assign txd    = tx_sh_q[0];

  always_comb begin
    tx_go   = 1'b0;
    tx_byte = '0;
    if (tx_rdy) begin
      unique case (1'b1)
        (st_q == HDR0): begin
          tx_go   = 1'b1;
          tx_byte = {7'b0, row_q[8]};
        end
        (st_q == HDR1): begin
          tx_go   = 1'b1;
          tx_byte = row_q[7:0];
        end
        (st_q == SEND3): begin
          tx_go   = 1'b1;
          tx_byte = sh_q[23:16];
        end
        (st_q == TRAIL): begin
          tx_go   = 1'b1;
          tx_byte = END_CODE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q <= 1'b0;
      tx_div_q  <= '0;
      tx_bits_q <= '0;
      tx_sh_q   <= '1;
    end else if (tx_go) begin
      tx_busy_q <= 1'b1;
      tx_div_q  <= DW'(DIV - 1);
      tx_bits_q <= 4'(NB - 1);
      tx_sh_q   <= {{STOP_BIT{1'b1}}, tx_byte, 1'b0};
    end else if (tx_busy_q) begin
      if (tx_div_q != '0) begin
        tx_div_q <= tx_div_q - 1'b1;
      end else if (tx_bits_q == '0) begin
        tx_busy_q <= 1'b0;
        tx_sh_q   <= '1;
      end else begin
        tx_bits_q <= tx_bits_q - 1'b1;
        tx_div_q  <= DW'(DIV - 1);
        tx_sh_q   <= {1'b1, tx_sh_q[NB-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      ram_rd    <= 1'b0;
      ram_addr  <= '0;
      row_q     <= '0;
      last_q    <= '0;
      ptr_q     <= '0;
      grp_q     <= '0;
      rd_cnt_q  <= '0;
      cap_cnt_q <= '0;
      byte_q    <= '0;
      sh_q      <= '0;
      pipe_q    <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
    end else begin
      done   <= 1'b0;
      ram_rd <= 1'b0;
      pipe_q <= RAM_LATENCY'({pipe_q, ram_rd});
      case (st_q)
        IDLE: if (start) begin
          if (row_first > row_last ||
              int'(row_last) >= Height) begin
            error <= 1'b1;
          end else begin
            error   <= 1'b0;
            busy    <= 1'b1;
            row_q   <= row_first;
            last_q  <= row_last;
            retry_q <= '0;
            st_q    <= HDR0;
          end
        end
        HDR0: begin
          ptr_q <= {10'b0, row_q} * WL + WL - 19'd1;
          grp_q <= GW'(Wight / 8);
          if (tx_rdy) st_q <= HDR1;
        end
        HDR1: if (tx_rdy) begin
          st_q      <= FETCH;
          rd_cnt_q  <= '0;
          cap_cnt_q <= '0;
        end
        FETCH: begin
          if (rd_cnt_q != 4'd8) begin
            ram_rd   <= 1'b1;
            ram_addr <= ptr_q;
            ptr_q    <= ptr_q - 19'd1;
            rd_cnt_q <= rd_cnt_q + 4'd1;
          end
          if (pipe_q[RAM_LATENCY-1]) begin
            sh_q      <= {sh_q[20:0], ram_q};
            cap_cnt_q <= cap_cnt_q + 3'd1;
            if (cap_cnt_q == 3'd7) begin
              st_q   <= SEND3;
              byte_q <= '0;
              grp_q  <= grp_q - 1'b1;
            end
          end
        end
        SEND3: if (tx_rdy) begin
          sh_q   <= sh_q << 8;
          byte_q <= byte_q + 2'd1;
          if (byte_q == 2'd2) begin
            if (grp_q == '0) begin
              st_q <= TRAIL;
            end else begin
              st_q      <= FETCH;
              rd_cnt_q  <= '0;
              cap_cnt_q <= '0;
            end
          end
        end
        TRAIL: if (tx_rdy) begin
          st_q  <= WAIT_ACK;
          tmo_q <= '0;
        end
        // Timer runs only once END_CODE has fully left the line.
        WAIT_ACK: begin
          if (ack_valid && ack_byte == ANSWER_CODE) begin
            st_q <= NEXT;
          end else if (!tx_busy_q) begin
            if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
              if (retry_q < RW'(MAX_RETRY)) begin
                retry_q <= retry_q + 1'b1;
                st_q    <= HDR0;
              end else begin
                error <= 1'b1;
                busy  <= 1'b0;
                st_q  <= IDLE;
              end
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        NEXT: begin
          retry_q <= '0;
          if (row_q == last_q) begin
            done <= 1'b1;
            busy <= 1'b0;
            st_q <= IDLE;
          end else begin
            row_q <= row_q + 9'd1;
            st_q  <= HDR0;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_uart_sender.sv
// Directed bench for frame_uart_sender: decodes txd, models the RAM
// and the acknowledging peer.
module tb_frame_uart_sender;

  localparam int W  = 64;
  localparam int H  = 480;
  localparam int PK = 3 * W / 8 + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  row_first = '0;
  logic [8:0]  row_last = '0;
  logic        busy, done, error;
  logic [18:0] ram_addr;
  logic        ram_rd;
  logic [2:0]  ram_q;
  logic        ack_valid = 1'b0;
  logic [7:0]  ack_byte = '0;
  logic        txd;

  frame_uart_sender #(
    .Wight(W), .Height(H), .CLK_FREQ(1_152_000), .BAUD(115200),
    .STOP_BIT(2), .END_CODE(8'hFF), .ANSWER_CODE(8'hAA),
    .RAM_LATENCY(2), .ACK_TIMEOUT(200), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .row_first(row_first), .row_last(row_last),
    .busy(busy), .done(done), .error(error),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q),
    .ack_valid(ack_valid), .ack_byte(ack_byte), .txd(txd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [2:0] mem [0:W*H-1];
  logic [2:0] p0 = '0, p1 = '0;
  always @(posedge clk) begin
    p0 <= (ram_rd && ram_addr < 19'(W*H)) ? mem[ram_addr] : 3'd0;
    p1 <= p0;
  end
  assign ram_q = p1;

  int rd_cnt = 0;
  int rd_min = 1 << 30;
  int rd_max = 0;
  int done_cnt = 0;
  int done_busy = 0;
  int low_cnt = 0;
  always @(negedge clk) begin
    if (ram_rd) begin
      rd_cnt++;
      if (int'(ram_addr) < rd_min) rd_min = int'(ram_addr);
      if (int'(ram_addr) > rd_max) rd_max = int'(ram_addr);
    end
    if (done) begin
      done_cnt++;
      if (busy) done_busy++;
    end
    if (!txd) low_cnt++;
  end

  logic [7:0] rx_q[$];
  int         st_q[$];
  int         ferr = 0;

  // UART decoder: samples every bit at its midpoint, DIV = 10.
  initial begin
    logic       prev;
    logic [7:0] b;
    int         c;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !txd) begin
        c = cyc;
        repeat (5) @(negedge clk);
        if (txd) ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = txd;
        end
        repeat (2) begin
          repeat (10) @(negedge clk);
          if (!txd) ferr++;
        end
        rx_q.push_back(b);
        st_q.push_back(c);
        prev = 1'b1;
      end else begin
        prev = txd;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [8:0] f, input logic [8:0] l);
    @(negedge clk);
    start = 1'b1;
    row_first = f;
    row_last = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_ack(input logic [7:0] b);
    @(negedge clk);
    ack_valid = 1'b1;
    ack_byte = b;
    @(negedge clk);
    ack_valid = 1'b0;
    ack_byte = '0;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    st_q.delete();
    rd_cnt = 0;
    rd_min = 1 << 30;
    rd_max = 0;
    ferr = 0;
  endtask

  initial begin
    int nz, gmin, gmax, mism, aa_cyc, k;
    for (int i = 0; i < W*H; i++) mem[i] = 3'd0;
    for (int x = 0; x < 8; x++) mem[5*W + x] = 3'(x);

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_txd", txd, 1);

    // Single row 5: packing, bit timing, read count
    clear_mon();
    do_start(9'd5, 9'd5);
    chk("t1_busy", busy, 1);
    wait_rx("t1_rx", PK, 4000);
    chk("t1_b0", rx_q[0], 8'h00);
    chk("t1_b1", rx_q[1], 8'h05);
    nz = 0;
    for (int i = 2; i < PK - 4; i++) if (rx_q[i] != 8'h00) nz++;
    chk("t1_zero_data", nz, 0);
    chk("t1_d_fa", rx_q[PK-4], 8'hFA);
    chk("t1_d_c6", rx_q[PK-3], 8'hC6);
    chk("t1_d_88", rx_q[PK-2], 8'h88);
    chk("t1_end", rx_q[PK-1], 8'hFF);
    gmin = 1 << 30;
    gmax = 0;
    for (int i = 0; i < PK - 1; i++) begin
      k = st_q[i+1] - st_q[i];
      if (k < gmin) gmin = k;
      if (k > gmax) gmax = k;
    end
    chk("t1_gap_min", gmin, 110);
    chk("t1_gap_max", gmax, 110);
    chk("t1_frame", ferr, 0);
    chk("t1_rd_cnt", rd_cnt, W);
    repeat (15) @(negedge clk);
    send_ack(8'hAA);
    wait_done("t1_done", 300);
    chk("t1_busy_end", busy, 0);

    // Rows 0..2 with a stray ack during the first packet
    clear_mon();
    k = done_cnt;
    done_busy = 0;
    do_start(9'd0, 9'd2);
    wait_rx("t2_rx_early", 5, 1000);
    send_ack(8'hAA);
    for (int r = 0; r < 3; r++) begin
      wait_rx("t2_rx", PK * (r + 1), 4000);
      chk("t2_b0", rx_q[PK*r], 8'h00);
      chk("t2_b1", rx_q[PK*r+1], 8'(r));
      repeat (15) @(negedge clk);
      send_ack(8'hAA);
    end
    wait_done("t2_done", 300);
    repeat (400) @(negedge clk);
    chk("t2_done_cnt", done_cnt - k, 1);
    chk("t2_done_busy", done_busy, 0);
    chk("t2_pkts", rx_q.size(), 3 * PK);
    chk("t2_frame", ferr, 0);

    // Row 300: header and address span
    clear_mon();
    do_start(9'd300, 9'd300);
    wait_rx("t3_rx", PK, 4000);
    chk("t3_b0", rx_q[0], 8'h01);
    chk("t3_b1", rx_q[1], 8'h2C);
    chk("t3_addr_min", rd_min, 300 * W);
    chk("t3_addr_max", rd_max, 300 * W + W - 1);
    chk("t3_rd_cnt", rd_cnt, W);
    repeat (15) @(negedge clk);
    send_ack(8'hAA);
    wait_done("t3_done", 300);

    // No acknowledge: 1 + 3 retries then error
    clear_mon();
    do_start(9'd7, 9'd7);
    k = 0;
    while (!error && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("t4_error", error, 1);
    chk("t4_busy", busy, 0);
    repeat (500) @(negedge clk);
    chk("t4_pkts", rx_q.size(), 4 * PK);
    mism = 0;
    for (int p = 1; p < 4; p++)
      for (int i = 0; i < PK; i++)
        if (rx_q.size() >= 4 * PK && rx_q[PK*p+i] != rx_q[i]) mism++;
    chk("t4_same", mism, 0);
    chk("t4_b1", rx_q[1], 8'h07);

    // Wrong acknowledge ignored, start while busy ignored
    clear_mon();
    k = done_cnt;
    do_start(9'd1, 9'd2);
    chk("t5_err_clr", error, 0);
    wait_rx("t5_rx1", PK, 4000);
    repeat (10) @(negedge clk);
    send_ack(8'h55);
    repeat (10) @(negedge clk);
    do_start(9'd9, 9'd9);
    repeat (10) @(negedge clk);
    aa_cyc = cyc;
    send_ack(8'hAA);
    wait_rx("t5_rx2", 2 * PK, 4000);
    chk("t5_after_aa", st_q[PK] > aa_cyc, 1);
    chk("t5_b1", rx_q[PK+1], 8'h02);
    repeat (15) @(negedge clk);
    send_ack(8'hAA);
    wait_done("t5_done", 300);
    chk("t5_done_cnt", done_cnt - k, 1);

    // Invalid range, then reset mid-packet
    clear_mon();
    low_cnt = 0;
    do_start(9'd10, 9'd5);
    @(negedge clk);
    chk("t6_error", error, 1);
    chk("t6_busy", busy, 0);
    repeat (200) @(negedge clk);
    chk("t6_txd_idle", low_cnt, 0);
    do_start(9'd3, 9'd3);
    chk("t6_err_clr", error, 0);
    wait_rx("t6_rx", 5, 1000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_txd", txd, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rd", ram_rd, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    low_cnt = 0;
    repeat (300) @(negedge clk);
    chk("t6_quiet", low_cnt, 0);
    do_start(9'd0, 9'd480);
    @(negedge clk);
    chk("t6_height", error, 1);
    chk("t6_height_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
